// File: rtl/uart_rx_frame.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, optional parity, 1-2 stop bits.
// RX_VALID pulses ~2 clocks after the mid-point of the last stop bit; no backpressure (strobe only).
module uart_rx_frame #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 FPGA_CLK,
    input  logic                 RST_N,
    input  logic                 UART_RXD,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    output logic                 PARITY_ERR,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] CNT_FULL      = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF      = CW'(CPB / 2 - 1);
    localparam logic [2:0]    IDX_DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    IDX_STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          ODD_PARITY    = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t                 state_q;
    logic                   sync1_q, sync2_q, prev_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_err_q, frm_err_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q, perr_out_q, ferr_out_q;

    logic rxd, fall, bit_end;
    assign rxd     = sync2_q;
    assign fall    = prev_q & ~sync2_q;
    assign bit_end = (cnt_q == CNT_FULL);

    always_ff @(posedge FPGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            sync1_q <= UART_RXD;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    // Edge-triggered start: a line held low (break) never retriggers.
                    if (fall) begin
                        state_q   <= S_START;
                        par_err_q <= 1'b0;
                        frm_err_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        state_q <= rxd ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        shift_q <= {rxd, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_DATA_LAST) begin
                            idx_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PAR: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        par_err_q <= (^shift_q) ^ rxd ^ ODD_PARITY;
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        // Returning at mid-stop leaves half a bit to catch a back-to-back start edge.
                        if (idx_q == IDX_STOP_LAST) begin
                            idx_q      <= '0;
                            data_q     <= shift_q;
                            valid_q    <= 1'b1;
                            perr_out_q <= (PARITY != 0) ? par_err_q : 1'b0;
                            ferr_out_q <= frm_err_q | ~rxd;
                            state_q    <= S_IDLE;
                        end else begin
                            frm_err_q <= frm_err_q | ~rxd;
                            idx_q     <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign RX_DATA    = data_q;
    assign RX_VALID   = valid_q;
    assign PARITY_ERR = perr_out_q;
    assign FRAME_ERR  = ferr_out_q;
    assign BUSY       = (state_q != S_IDLE);

endmodule
